data_memory_bank: RTL and testbench

Parametrised successor to the single-cycle data memory: a byte-addressed, little-endian data RAM for the pipelined CPU's MEM stage. Configurable word width and depth, byte/half/word stores via byte lanes, signed or unsigned sub-word loads, registered reads, and misalignment detection. Reset triggers a hardware clear sweep so that arbitrary depths are zeroed without a one-cycle bulk reset.

---
 rtl/data_memory_bank.sv | 179 +++++++++++++++++
 tb/tb_data_memory_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bank.sv
// data_memory_bank: byte-addressed, little-endian data RAM for the MEM stage.
// After reset, a hardware sweep zeroes one word per cycle. Requests are
// accepted once the sweep ends. Stores use byte lanes. Loads are registered
// and sign- or zero-extended. A misaligned access is rejected and flagged
// one cycle later.
module data_memory_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Write_data,
    output logic [DATA_WIDTH-1:0] Read_data,
    output logic                  Read_valid,
    output logic                  Ready,
    output logic                  Misaligned
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       clear_count;
    logic                   ready_q;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // Address decode
    logic [IDX_W-1:0]       word_idx;
    logic [OFF_W-1:0]       byte_off;
    logic [OFF_W+2:0]       off_bits;

    // Access size and alignment
    logic [1:0]             size_eff;
    logic [OFF_W:0]         num_bytes;
    logic [OFF_W+3:0]       size_bits;
    logic [OFF_W+3:0]       sign_pos;
    logic                   aligned;

    // Request qualification
    logic                   rd_req;
    logic                   wr_req;
    logic                   wr_fire;

    // Store path
    logic [BYTES-1:0]       lane_en;
    logic [DATA_WIDTH-1:0]  wr_shifted;

    // Load path
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0]  rd_shifted;
    logic [DATA_WIDTH-1:0]  keep_mask;
    logic [DATA_WIDTH-1:0]  sign_mask;
    logic [DATA_WIDTH-1:0]  ld_ext;
    logic                   fill_bit;

    // The word index and the byte offset come from the low address bits.
    // Higher bits are dropped, so addresses wrap modulo DEPTH*BYTES.
    assign word_idx = Address[OFF_W+IDX_W-1:OFF_W];
    assign byte_off = Address[OFF_W-1:0];
    assign off_bits = {byte_off, 3'b000};

    generate
        if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_addr_high
            logic unused_addr_high;
            assign unused_addr_high = ^Address[ADDR_WIDTH-1:OFF_W+IDX_W];
        end
    endgenerate

    assign Ready   = ready_q;
    assign rd_req  = ready_q & MemRead;
    assign wr_req  = ready_q & MemWrite;
    assign wr_fire = wr_req & aligned & ~reset;

    // Clamp the access size to a full word and check alignment.
    always_comb begin
        // NOTE: each signal gets a value on every path through the block,
        // starting with a default, so no latch is inferred.
        size_eff = Size;
        if (int'(Size) > OFF_W) begin
            size_eff = 2'(OFF_W);
        end
        num_bytes = (OFF_W + 1)'(1) << size_eff;
        size_bits = {num_bytes, 3'b000};
        sign_pos  = size_bits - 1'b1;
        aligned   = (byte_off & OFF_W'(num_bytes - 1'b1)) == '0;
    end

    // Place the store data on its byte lanes and enable only those lanes.
    always_comb begin
        lane_en    = (~({BYTES{1'b1}} << num_bytes)) << byte_off;
        wr_shifted = Write_data << off_bits;
    end

    // Extract the addressed bytes and extend them to a full word.
    always_comb begin
        rd_word    = mem[word_idx];
        rd_shifted = rd_word >> off_bits;
        keep_mask  = ~({DATA_WIDTH{1'b1}} << size_bits);
        sign_mask  = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << sign_pos;
        fill_bit   = ~Unsigned & (|(rd_shifted & sign_mask));
        ld_ext     = (rd_shifted & keep_mask) | ({DATA_WIDTH{fill_bit}} & ~keep_mask);
    end

    // Control FSM: sweep every word in CLEAR, then stay in IDLE until reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before this edge.
        if (reset) begin
            state       <= CLEAR;
            clear_count <= '0;
            ready_q     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_count <= clear_count + 1'b1;
                    if (clear_count == IDX_W'(DEPTH - 1)) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= CLEAR;
                    clear_count <= '0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: sweep zeroes in CLEAR, byte-lane stores in IDLE.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term. The sweep zeroes it, so it can
        // still map onto a plain RAM macro.
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clear_count] <= '0;
            end else if (wr_fire) begin
                for (int l = 0; l < BYTES; l++) begin
                    if (lane_en[l]) begin
                        mem[word_idx][l*8 +: 8] <= wr_shifted[l*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered load result and status pulses. The array is read before
    // this edge's store lands, which gives read-before-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            Read_data  <= '0;
            Read_valid <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            Read_valid <= rd_req;
            Misaligned <= (rd_req | wr_req) & ~aligned;
            if (rd_req) begin
                Read_data <= aligned ? ld_ext : '0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// tb_data_memory_bank: directed test of data_memory_bank. It uses the default
// 32-bit x 256 instance and a 64-bit x 16 variant, with hand-computed values.
module tb_data_memory_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Default instance: DATA_WIDTH=32, DEPTH=256
    logic        m_rd, m_wr, m_uns;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_valid, m_ready, m_mis;

    // Variant instance: DATA_WIDTH=64, DEPTH=16
    logic        v_rd, v_wr, v_uns;
    logic [1:0]  v_size;
    logic [31:0] v_addr;
    logic [63:0] v_wdata, v_rdata;
    logic        v_valid, v_ready, v_mis;

    int checks = 0;
    int errors = 0;

    data_memory_bank #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (m_rd),
        .MemWrite   (m_wr),
        .Size       (m_size),
        .Unsigned   (m_uns),
        .Address    (m_addr),
        .Write_data (m_wdata),
        .Read_data  (m_rdata),
        .Read_valid (m_valid),
        .Ready      (m_ready),
        .Misaligned (m_mis)
    );

    data_memory_bank #(.DATA_WIDTH(64), .DEPTH(16), .ADDR_WIDTH(32)) dut_wide (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (v_rd),
        .MemWrite   (v_wr),
        .Size       (v_size),
        .Unsigned   (v_uns),
        .Address    (v_addr),
        .Write_data (v_wdata),
        .Read_data  (v_rdata),
        .Read_valid (v_valid),
        .Ready      (v_ready),
        .Misaligned (v_mis)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge. Outputs are valid on return.
    task automatic m_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        m_rd = rd; m_wr = wr; m_size = sz; m_uns = uns; m_addr = addr; m_wdata = wd;
        @(posedge clk); #1;
        m_rd = 1'b0; m_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic v_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [63:0] wd);
        v_rd = rd; v_wr = wr; v_size = sz; v_uns = uns; v_addr = addr; v_wdata = wd;
        @(posedge clk); #1;
        v_rd = 1'b0; v_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue a request and sample the outputs right after the following edge.
    task automatic m_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        m_rd = rd; m_wr = wr; m_size = sz; m_uns = uns; m_addr = addr; m_wdata = wd;
        @(posedge clk); #1;
        m_rd = 1'b0; m_wr = 1'b0;
    endtask

    task automatic v_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [63:0] wd);
        v_rd = rd; v_wr = wr; v_size = sz; v_uns = uns; v_addr = addr; v_wdata = wd;
        @(posedge clk); #1;
        v_rd = 1'b0; v_wr = 1'b0;
    endtask

    task automatic m_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
        m_req(1'b1, 1'b0, sz, uns, addr, 32'h0);
        check(tag, {32'h0, m_rdata}, {32'h0, exp});
        check("load_valid", {63'h0, m_valid}, 64'h1);
    endtask

    task automatic v_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [63:0] exp);
        v_req(1'b1, 1'b0, sz, uns, addr, 64'h0);
        check(tag, v_rdata, exp);
        check("wide_load_valid", {63'h0, v_valid}, 64'h1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("ready_in_reset", {63'h0, m_ready}, 64'h0);
    endtask

    // Count edges after the reset edge until each instance reports Ready.
    task automatic wait_ready(input int exp_main, input int exp_wide);
        int nm = 0;
        int nv = 0;
        for (int n = 1; n <= 1000 && (nm == 0 || nv == 0); n++) begin
            @(posedge clk); #1;
            if (nm == 0 && m_ready) nm = n;
            if (nv == 0 && v_ready) nv = n;
        end
        check("clear_latency_main", 64'(nm), 64'(exp_main));
        check("clear_latency_wide", 64'(nv), 64'(exp_wide));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        m_rd = 0; m_wr = 0; m_size = 0; m_uns = 0; m_addr = 0; m_wdata = 0;
        v_rd = 0; v_wr = 0; v_size = 0; v_uns = 0; v_addr = 0; v_wdata = 0;

        // Reset values
        pulse_reset();
        check("rst_read_data",  {32'h0, m_rdata}, 64'h0);
        check("rst_read_valid", {63'h0, m_valid}, 64'h0);
        check("rst_misaligned", {63'h0, m_mis},   64'h0);
        check("rst_wide_ready", {63'h0, v_ready}, 64'h0);
        wait_ready(256, 16);

        // Preload garbage, then check that a reset sweep clears it
        m_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h000, 32'hDEADBEEF);
        m_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hDEADBEEF);
        m_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
        m_load("garbage_present", 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
        pulse_reset();
        wait_ready(256, 16);
        m_load("cleared_0x000", 2'b10, 1'b0, 32'h000, 32'h0);
        m_load("cleared_0x3fc", 2'b10, 1'b0, 32'h3FC, 32'h0);
        m_load("cleared_0x200", 2'b10, 1'b0, 32'h200, 32'h0);

        // Byte and half stores, then signed and unsigned sub-word loads
        m_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD);
        m_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000080);
        m_load("lw_0x10", 2'b10, 1'b0, 32'h10, 32'hAABB80DD);
        m_load("lb_0x11", 2'b00, 1'b0, 32'h11, 32'hFFFFFF80);
        m_load("lbu_0x11", 2'b00, 1'b1, 32'h11, 32'h00000080);
        m_load("lh_0x12", 2'b01, 1'b0, 32'h12, 32'hFFFFAABB);
        m_load("lhu_0x12", 2'b01, 1'b1, 32'h12, 32'h0000AABB);
        m_load("lbu_0x10", 2'b00, 1'b1, 32'h10, 32'h000000DD);
        // Size=11 clamps to a full word on a 32-bit bank
        m_load("size3_clamped", 2'b11, 1'b1, 32'h10, 32'hAABB80DD);
        check("clamp_not_misaligned", {63'h0, m_mis}, 64'h0);

        // Misalignment
        m_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        m_load("lw_0x22_data", 2'b10, 1'b0, 32'h22, 32'h0);
        check("lw_0x22_mis", {63'h0, m_mis}, 64'h1);
        m_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h23, 32'h00001234);
        check("sh_0x23_mis", {63'h0, m_mis}, 64'h1);
        check("sh_0x23_valid", {63'h0, m_valid}, 64'h0);
        m_load("word_0x20_kept", 2'b10, 1'b0, 32'h20, 32'h11223344);
        check("aligned_no_mis", {63'h0, m_mis}, 64'h0);
        @(posedge clk); #1;
        check("idle_valid_low", {63'h0, m_valid}, 64'h0);
        check("idle_data_held", {32'h0, m_rdata}, 64'h11223344);
        check("idle_mis_low", {63'h0, m_mis}, 64'h0);

        // Read-before-write, then the new value is visible
        m_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'd5);
        m_load("rbw_old_value", 2'b10, 1'b0, 32'h40, 32'd5);
        m_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'd9);
        check("rbw_same_cycle", {32'h0, m_rdata}, 64'd5);
        m_load("rbw_new_value", 2'b10, 1'b0, 32'h40, 32'd9);
        // Misaligned combined access rejects both operations
        m_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h42, 32'h99);
        check("both_mis_flag", {63'h0, m_mis}, 64'h1);
        check("both_mis_valid", {63'h0, m_valid}, 64'h1);
        check("both_mis_data", {32'h0, m_rdata}, 64'h0);
        m_load("both_mis_no_write", 2'b10, 1'b0, 32'h40, 32'd9);

        // Address wrap modulo 1 KiB
        m_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678);
        m_load("wrap_0x000", 2'b10, 1'b0, 32'h000, 32'h12345678);

        // Reset in the middle of a sweep; requests are ignored while not ready
        pulse_reset();
        m_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h41, 32'h77);
        check("sweep_ignored_valid", {63'h0, m_valid}, 64'h0);
        check("sweep_ignored_mis", {63'h0, m_mis}, 64'h0);
        repeat (98) @(posedge clk);
        #1;
        check("mid_sweep_not_ready", {63'h0, m_ready}, 64'h0);
        pulse_reset();
        wait_ready(256, 16);
        m_load("resweep_0x40", 2'b10, 1'b0, 32'h40, 32'h0);
        m_load("resweep_0x10", 2'b10, 1'b0, 32'h10, 32'h0);

        // 64-bit variant
        v_access(1'b0, 1'b1, 2'b11, 1'b0, 32'h8, 64'h0123456789ABCDEF);
        v_load("w_lw_0xc", 2'b10, 1'b0, 32'hC, 64'h0000000001234567);
        v_load("w_lwu_0xc", 2'b10, 1'b1, 32'hC, 64'h0000000001234567);
        v_load("w_lw_0x8", 2'b10, 1'b0, 32'h8, 64'hFFFFFFFF89ABCDEF);
        v_load("w_lwu_0x8", 2'b10, 1'b1, 32'h8, 64'h0000000089ABCDEF);
        v_load("w_lb_0xb", 2'b00, 1'b0, 32'hB, 64'hFFFFFFFFFFFFFF89);
        v_load("w_lh_0xe", 2'b01, 1'b0, 32'hE, 64'h0000000000000123);
        v_load("w_ld_wrap", 2'b11, 1'b0, 32'h88, 64'h0123456789ABCDEF);
        v_load("w_ld_0x4_data", 2'b11, 1'b0, 32'h4, 64'h0);
        check("w_ld_0x4_mis", {63'h0, v_mis}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
